// File: rtl/context_restore_sequencer_if.sv
// rtl/context_restore_sequencer_if.sv - restore request and register-file write port bundle
interface context_restore_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);
   logic                  start;
   logic [3:0]            mask;
   logic [DATA_WIDTH-1:0] saved_mary;
   logic [DATA_WIDTH-1:0] saved_shelley;
   logic [DATA_WIDTH-1:0] saved_comp;
   logic [DATA_WIDTH-1:0] saved_ra;
   logic                  wr_ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, mask, saved_mary, saved_shelley, saved_comp, saved_ra, wr_ready,
      output wr_en, wr_addr, wr_data, busy, done
   );

   modport slave (
      output start, mask, saved_mary, saved_shelley, saved_comp, saved_ra, wr_ready,
      input  wr_en, wr_addr, wr_data, busy, done
   );
endinterface

// File: rtl/context_restore_sequencer.sv
// rtl/context_restore_sequencer.sv - writes shadowed mary/shelley/comp/ra back to the register file
// Snapshot on start, one write per selected register, then a single done pulse.
module context_restore_sequencer #(
   parameter int                  DATA_WIDTH   = 16,
   parameter int                  ADDR_WIDTH   = 4,
   parameter logic [ADDR_WIDTH-1:0] MARY_ADDR    = 4'd1,
   parameter logic [ADDR_WIDTH-1:0] SHELLEY_ADDR = 4'd2,
   parameter logic [ADDR_WIDTH-1:0] COMP_ADDR    = 4'd3,
   parameter logic [ADDR_WIDTH-1:0] RA_ADDR      = 4'd15
) (
   input logic                          clock,
   input logic                          reset,
   context_restore_sequencer_if.master  bus
);
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      W_MARY    = 3'd1,
      W_SHELLEY = 3'd2,
      W_COMP    = 3'd3,
      W_RA      = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            mask_q, mask_d;
   logic [DATA_WIDTH-1:0] mary_q, mary_d;
   logic [DATA_WIDTH-1:0] shelley_q, shelley_d;
   logic [DATA_WIDTH-1:0] comp_q, comp_d;
   logic [DATA_WIDTH-1:0] ra_q, ra_d;

   // First selected write slot at or after position 'from' (0=mary .. 3=ra).
   function automatic state_t next_sel(input logic [3:0] m, input logic [2:0] from);
      if (m[0] && from == 3'd0)
         return W_MARY;
      else if (m[1] && from <= 3'd1)
         return W_SHELLEY;
      else if (m[2] && from <= 3'd2)
         return W_COMP;
      else if (m[3] && from <= 3'd3)
         return W_RA;
      else
         return DONE;
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         mary_q    <= '0;
         shelley_q <= '0;
         comp_q    <= '0;
         ra_q      <= '0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         mary_q    <= mary_d;
         shelley_q <= shelley_d;
         comp_q    <= comp_d;
         ra_q      <= ra_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      mary_d    = mary_q;
      shelley_d = shelley_q;
      comp_d    = comp_q;
      ra_d      = ra_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mask_d    = bus.mask;
               mary_d    = bus.saved_mary;
               shelley_d = bus.saved_shelley;
               comp_d    = bus.saved_comp;
               ra_d      = bus.saved_ra;
               state_d   = next_sel(bus.mask, 3'd0);
            end
         end
         W_MARY:    if (bus.wr_ready) state_d = next_sel(mask_q, 3'd1);
         W_SHELLEY: if (bus.wr_ready) state_d = next_sel(mask_q, 3'd2);
         W_COMP:    if (bus.wr_ready) state_d = next_sel(mask_q, 3'd3);
         W_RA:      if (bus.wr_ready) state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Outputs depend on registered state only, so reset clears them without a clock.
   always_comb begin
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.busy    = (state_q != IDLE);
      bus.done    = (state_q == DONE);
      case (state_q)
         W_MARY: begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = MARY_ADDR;
            bus.wr_data = mary_q;
         end
         W_SHELLEY: begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = SHELLEY_ADDR;
            bus.wr_data = shelley_q;
         end
         W_COMP: begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = COMP_ADDR;
            bus.wr_data = comp_q;
         end
         W_RA: begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = RA_ADDR;
            bus.wr_data = ra_q;
         end
         default: ;
      endcase
   end
endmodule
